// File: rtl/cordic_pipe.sv
// cordic_pipe: pipelined fixed-point CORDIC in integer degrees, rotation or vectoring mode.
// Pre-rotation register, STAGES micro-rotation registers and a saturating output register share one stall signal.
module cordic_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic signed [W:0] x_in,
  input  logic signed [W:0] y_in,
  input  logic signed [W:0] z_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [W:0] x_out,
  output logic signed [W:0] y_out,
  output logic signed [W:0] eps,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int IW = W + 3;
  typedef logic signed [IW-1:0] iw_t;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } mode_e;

  localparam iw_t NINETY  = iw_t'(90);
  localparam iw_t SAT_MAX = iw_t'((1 << W) - 1);
  localparam iw_t SAT_MIN = ~SAT_MAX;

  function automatic iw_t angle(input int unsigned i);
    case (i)
      1:       angle = iw_t'(45);
      2:       angle = iw_t'(26);
      3:       angle = iw_t'(14);
      4:       angle = iw_t'(7);
      5:       angle = iw_t'(4);
      6:       angle = iw_t'(2);
      default: angle = iw_t'(1);
    endcase
  endfunction

  function automatic logic signed [W:0] sat(input iw_t v);
    if (v > SAT_MAX)      sat = SAT_MAX[W:0];
    else if (v < SAT_MIN) sat = SAT_MIN[W:0];
    else                  sat = v[W:0];
  endfunction

  logic  advance;
  iw_t   xe, ye, ze;
  iw_t   xp, yp, zp;
  mode_e mode_in;

  // Stage 0 is the pre-rotation register; stage i holds the result of micro-rotation i.
  iw_t   xs [STAGES+1];
  iw_t   ys [STAGES+1];
  iw_t   zs [STAGES+1];
  logic  vs [STAGES+1];
  mode_e ms [STAGES+1];

  iw_t          nx [1:STAGES];
  iw_t          ny [1:STAGES];
  iw_t          nz [1:STAGES];
  logic [STAGES:1] dpos;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign mode_in  = mode_e'(mode);

  assign xe = {{2{x_in[W]}}, x_in};
  assign ye = {{2{y_in[W]}}, y_in};
  assign ze = {{2{z_in[W]}}, z_in};

  // Quadrant fold so the micro-rotations only need to cover +/-90 degrees.
  always_comb begin
    xp = xe;
    yp = ye;
    zp = ze;
    if (mode_in == ROTATE) begin
      if (ze > NINETY) begin
        xp = -ye;
        yp = xe;
        zp = ze - NINETY;
      end else if (ze < -NINETY) begin
        xp = ye;
        yp = -xe;
        zp = ze + NINETY;
      end
    end else if (xe[IW-1]) begin
      if (!ye[IW-1]) begin
        xp = ye;
        yp = -xe;
        zp = ze + NINETY;
      end else begin
        xp = -ye;
        yp = xe;
        zp = ze - NINETY;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 1; i <= STAGES; i++) begin
      if (ms[i-1] == ROTATE) dpos[i] = !zs[i-1][IW-1];
      else                   dpos[i] = ys[i-1][IW-1];
      if (dpos[i]) begin
        nx[i] = xs[i-1] - (ys[i-1] >>> (i - 1));
        ny[i] = ys[i-1] + (xs[i-1] >>> (i - 1));
        nz[i] = zs[i-1] - angle(i);
      end else begin
        nx[i] = xs[i-1] + (ys[i-1] >>> (i - 1));
        ny[i] = ys[i-1] - (xs[i-1] >>> (i - 1));
        nz[i] = zs[i-1] + angle(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i <= STAGES; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        zs[i] <= '0;
        vs[i] <= 1'b0;
        ms[i] <= ROTATE;
      end
      x_out     <= '0;
      y_out     <= '0;
      eps       <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      xs[0] <= xp;
      ys[0] <= yp;
      zs[0] <= zp;
      vs[0] <= in_valid;
      ms[0] <= mode_in;
      for (int unsigned i = 1; i <= STAGES; i++) begin
        xs[i] <= nx[i];
        ys[i] <= ny[i];
        zs[i] <= nz[i];
        vs[i] <= vs[i-1];
        ms[i] <= ms[i-1];
      end
      x_out     <= sat(xs[STAGES]);
      y_out     <= sat(ys[STAGES]);
      eps       <= sat(zs[STAGES]);
      out_valid <= vs[STAGES];
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: directed vectors with hand-computed results, stall and mid-stream reset.
`timescale 1ns/1ps
module tb_cordic_pipe;

  localparam int W      = 8;
  localparam int STAGES = 3;
  localparam int NVEC   = 12;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              mode      = 1'b0;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b1;
  logic signed [W:0] x_in      = '0;
  logic signed [W:0] y_in      = '0;
  logic signed [W:0] z_in      = '0;
  logic              in_ready;
  logic              out_valid;
  logic signed [W:0] x_out, y_out, eps;

  cordic_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .eps       (eps),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { bit m; int x; int y; int z; int ex; int ey; int ez; } vec_t;
  typedef struct { int x; int y; int z; int c; bit lat; int id; } exp_t;

  vec_t vecs [NVEC];
  exp_t q [$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample is taken.
  task automatic send(input int k, input bit lat);
    int waited = 0;
    mode     = vecs[k].m;
    x_in     = vecs[k].x[W:0];
    y_in     = vecs[k].y[W:0];
    z_in     = vecs[k].z[W:0];
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{vecs[k].ex, vecs[k].ey, vecs[k].ez, cyc, lat, k});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout v%0d: in_ready low for %0d cycles, required acceptance", k, waited);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain(input int limit);
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
  endtask

  // Monitor: pops on every output handshake and checks that stalled outputs stay frozen.
  logic signed [W:0] hx, hy, hz;
  bit                held = 1'b0;

  always @(negedge clk) begin
    if (held) begin
      check("hold_x_out", x_out, hx);
      check("hold_y_out", y_out, hy);
      check("hold_eps", eps, hz);
      check("hold_out_valid", out_valid, 1);
    end
    held = out_valid && !out_ready && reset_n;
    hx   = x_out;
    hy   = y_out;
    hz   = eps;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        check($sformatf("x_out v%0d", e.id), x_out, e.x);
        check($sformatf("y_out v%0d", e.id), y_out, e.y);
        check($sformatf("eps v%0d", e.id), eps, e.z);
        if (e.lat) check($sformatf("latency v%0d", e.id), cyc - e.c, STAGES + 2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0,  100,    0,    0,  162,   13,   -5};
    vecs[1]  = '{1'b0,  255,    0,    0,  255,   33,   -5};
    vecs[2]  = '{1'b1,  100,    0,    0,  163,  -13,    5};
    vecs[3]  = '{1'b0,  100,    0,  120,  -87,  137,   -3};
    vecs[4]  = '{1'b0,  100,    0, -120,  -88, -137,    3};
    vecs[5]  = '{1'b1, -100,   50,    0,  182,   18,  147};
    vecs[6]  = '{1'b1, -100,  -50,    0,  181,  -18, -147};
    vecs[7]  = '{1'b0, -256, -256,   45,  128, -256,  -12};
    vecs[8]  = '{1'b0,  100,    0,   90,   13,  162,    5};
    vecs[9]  = '{1'b0,  100,    0,  -90,   12, -162,   -5};
    vecs[10] = '{1'b0,  100,    0,  180, -162,   12,    5};
    vecs[11] = '{1'b1, -100,    0,    0,  162,   13,  175};

    #1;
    check("reset_x_out", x_out, 0);
    check("reset_y_out", y_out, 0);
    check("reset_eps", eps, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Isolated samples: results, latency and a single-cycle out_valid.
    for (int k = 0; k < NVEC; k++) begin
      send(k, 1'b1);
      drain(30);
      @(negedge clk);
      check($sformatf("one_cycle_valid v%0d", k), out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Back-to-back stream against a 10-cycle downstream stall.
    out_ready = 1'b0;
    fork
      for (int k = 0; k < 8; k++) send(k, 1'b0);
      begin
        int t = 0;
        while (!out_valid && t < 30) begin
          @(negedge clk);
          t++;
        end
        check("stall_out_valid", out_valid, 1);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(60);
    @(posedge clk);
    #1;

    // Reset with three samples in flight: nothing stale may emerge.
    for (int k = 0; k < 3; k++) send(k + 3, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    check("midreset_out_valid", out_valid, 0);
    check("midreset_x_out", x_out, 0);
    check("midreset_y_out", y_out, 0);
    check("midreset_eps", eps, 0);
    check("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(0, 1'b1);
    drain(30);
    @(negedge clk);
    check("after_reset_one_cycle", out_valid, 0);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
